// File: rtl/ddr_pkg.sv
// Shared constants for the DDR burst sequencer: command pin encodings,
// FSM state codes and the DM idle value.
package ddr_pkg;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;

    localparam logic [1:0] DM_MASKED = 2'b11;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ACT     = 4'd1;
    localparam logic [3:0] ST_TRCD_W  = 4'd2;
    localparam logic [3:0] ST_RW_CMD  = 4'd3;
    localparam logic [3:0] ST_WR_DATA = 4'd4;
    localparam logic [3:0] ST_WR_POST = 4'd5;
    localparam logic [3:0] ST_TWR_W   = 4'd6;
    localparam logic [3:0] ST_RD_WAIT = 4'd7;
    localparam logic [3:0] ST_RD_DATA = 4'd8;
    localparam logic [3:0] ST_PRE     = 4'd9;
    localparam logic [3:0] ST_TRP_W   = 4'd10;
    localparam logic [3:0] ST_REF     = 4'd11;
    localparam logic [3:0] ST_TRFC_W  = 4'd12;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_wait_ctr.sv
// Loadable down-counter shared by every timed state of the sequencer;
// done_o is high while the count sits at zero.
module ddr_wait_ctr #(
    parameter int W = 4
) (
    input  logic         clock_i,
    input  logic         reset_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins; otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == '0);

endmodule

// File: rtl/ddr_burst_seq.sv
// Closed-page DDR access sequencer: ACT -> READ/WRITE -> PRE per request,
// with refresh arbitration and DQS/DM/capture-window control for iobs_flow.
module ddr_burst_seq
    import ddr_pkg::*;
#(
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 10,
    parameter int BANK_BITS = 2,
    parameter int TRCD      = 2,
    parameter int CL        = 2,
    parameter int BL        = 4,
    parameter int TWR       = 2,
    parameter int TRP       = 2,
    parameter int TRFC      = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 req_i,
    input  logic                 rnw_i,
    input  logic [BANK_BITS-1:0] bank_i,
    input  logic [ROW_BITS-1:0]  row_i,
    input  logic [COL_BITS-1:0]  col_i,
    input  logic [1:0]           be_i,
    output logic                 ack_o,
    output logic                 busy_o,
    output logic                 wr_next_o,
    output logic                 rd_valid_o,
    input  logic                 ref_req_i,
    output logic                 ref_ack_o,
    output logic [2:0]           ddr_cmd_o,
    output logic [BANK_BITS-1:0] ddr_ba_o,
    output logic [ROW_BITS-1:0]  ddr_a_o,
    output logic [1:0]           ctl_dm_o,
    output logic [1:0]           ctl_dqs_o,
    output logic                 ctl_dqs_oe_o
);

    localparam int MAXW = imax(imax(imax(TRCD, CL), imax(BL / 2, TWR)), imax(TRP, TRFC));
    localparam int CW   = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

    // A state entered with load value k lasts k+1 clocks.
    localparam logic [CW-1:0] LD_TRCD  = (TRCD > 1) ? CW'(TRCD - 2) : '0;
    localparam logic [CW-1:0] LD_CL    = (CL > 1)   ? CW'(CL - 2)   : '0;
    localparam logic [CW-1:0] LD_BURST = CW'(BL / 2 - 1);
    localparam logic [CW-1:0] LD_TWR   = (TWR > 0)  ? CW'(TWR - 1)  : '0;
    localparam logic [CW-1:0] LD_TRP   = (TRP > 0)  ? CW'(TRP - 1)  : '0;
    localparam logic [CW-1:0] LD_TRFC  = (TRFC > 0) ? CW'(TRFC - 1) : '0;

    logic [3:0]           state_q, state_d;
    logic                 rnw_q;
    logic [BANK_BITS-1:0] bank_q;
    logic [COL_BITS-1:0]  col_q;

    logic                 accept_s;
    logic                 load_s;
    logic [CW-1:0]        load_val_s;
    logic [CW-1:0]        cnt_s;
    logic                 done_s;
    logic                 data_last_s;

    logic [2:0]           cmd_q, cmd_d;
    logic [BANK_BITS-1:0] ba_q, ba_d;
    logic [ROW_BITS-1:0]  a_q, a_d;
    logic [1:0]           dm_q, dm_d;
    logic [1:0]           dqs_q, dqs_d;
    logic                 oe_q, oe_d;
    logic                 ack_q, ack_d;
    logic                 ref_ack_q, ref_ack_d;
    logic                 wr_next_q, wr_next_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 busy_q, busy_d;

    assign accept_s = (state_q == ST_IDLE) && !ref_req_i && req_i;

    // Sequencer next state; zero-length waits are skipped entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_req_i) begin
                    state_d = ST_REF;
                end else if (req_i) begin
                    state_d = ST_ACT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACT:     state_d = (TRCD > 1) ? ST_TRCD_W : ST_RW_CMD;
            ST_TRCD_W:  state_d = done_s ? ST_RW_CMD : ST_TRCD_W;
            ST_RW_CMD: begin
                if (rnw_q) begin
                    state_d = (CL > 1) ? ST_RD_WAIT : ST_RD_DATA;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: state_d = done_s ? ST_WR_POST : ST_WR_DATA;
            ST_WR_POST: state_d = (TWR > 0) ? ST_TWR_W : ST_PRE;
            ST_TWR_W:   state_d = done_s ? ST_PRE : ST_TWR_W;
            ST_RD_WAIT: state_d = done_s ? ST_RD_DATA : ST_RD_WAIT;
            ST_RD_DATA: state_d = done_s ? ST_PRE : ST_RD_DATA;
            ST_PRE:     state_d = (TRP > 0) ? ST_TRP_W : ST_IDLE;
            ST_TRP_W:   state_d = done_s ? ST_IDLE : ST_TRP_W;
            ST_REF:     state_d = (TRFC > 0) ? ST_TRFC_W : ST_IDLE;
            ST_TRFC_W:  state_d = done_s ? ST_IDLE : ST_TRFC_W;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Counter is reloaded on every state change with the new state's length.
    always_comb begin
        load_s     = (state_d != state_q);
        load_val_s = '0;
        case (state_d)
            ST_TRCD_W:  load_val_s = LD_TRCD;
            ST_RD_WAIT: load_val_s = LD_CL;
            ST_WR_DATA: load_val_s = LD_BURST;
            ST_RD_DATA: load_val_s = LD_BURST;
            ST_TWR_W:   load_val_s = LD_TWR;
            ST_TRP_W:   load_val_s = LD_TRP;
            ST_TRFC_W:  load_val_s = LD_TRFC;
            default:    load_val_s = '0;
        endcase
    end

    ddr_wait_ctr #(.W(CW)) u_wait_ctr (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .count_o    (cnt_s),
        .done_o     (done_s)
    );

    // The next clock is the final data clock when the counter will read zero.
    assign data_last_s = load_s ? (load_val_s == '0) : (cnt_s == CW'(1));

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        cmd_d      = CMD_NOP;
        ba_d       = ba_q;
        a_d        = a_q;
        dm_d       = DM_MASKED;
        dqs_d      = 2'b00;
        oe_d       = 1'b0;
        ack_d      = 1'b0;
        ref_ack_d  = 1'b0;
        wr_next_d  = 1'b0;
        rd_valid_d = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_ACT: begin
                cmd_d = CMD_ACT;
                ba_d  = bank_i;
                a_d   = row_i;
            end
            ST_RW_CMD: begin
                cmd_d = rnw_q ? CMD_READ : CMD_WRITE;
                ba_d  = bank_q;
                a_d   = '0;
                a_d[COL_BITS-1:0] = col_q;
                oe_d  = !rnw_q;
            end
            ST_WR_DATA: begin
                dm_d      = ~be_i;
                dqs_d     = 2'b11;
                oe_d      = 1'b1;
                wr_next_d = 1'b1;
                ack_d     = data_last_s;
            end
            ST_WR_POST: begin
                oe_d = 1'b1;
            end
            ST_RD_DATA: begin
                rd_valid_d = 1'b1;
                ack_d      = data_last_s;
            end
            ST_PRE: begin
                cmd_d   = CMD_PRE;
                a_d     = '0;
                a_d[10] = 1'b1;
            end
            ST_REF: begin
                cmd_d     = CMD_REF;
                ref_ack_d = 1'b1;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    // State and request capture registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            rnw_q   <= 1'b0;
            bank_q  <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                rnw_q  <= rnw_i;
                bank_q <= bank_i;
                col_q  <= col_i;
            end else begin
                rnw_q  <= rnw_q;
                bank_q <= bank_q;
                col_q  <= col_q;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cmd_q      <= CMD_NOP;
            ba_q       <= '0;
            a_q        <= '0;
            dm_q       <= DM_MASKED;
            dqs_q      <= 2'b00;
            oe_q       <= 1'b0;
            ack_q      <= 1'b0;
            ref_ack_q  <= 1'b0;
            wr_next_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            a_q        <= a_d;
            dm_q       <= dm_d;
            dqs_q      <= dqs_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
            ref_ack_q  <= ref_ack_d;
            wr_next_q  <= wr_next_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign ddr_cmd_o    = cmd_q;
    assign ddr_ba_o     = ba_q;
    assign ddr_a_o      = a_q;
    assign ctl_dm_o     = dm_q;
    assign ctl_dqs_o    = dqs_q;
    assign ctl_dqs_oe_o = oe_q;
    assign ack_o        = ack_q;
    assign ref_ack_o    = ref_ack_q;
    assign wr_next_o    = wr_next_q;
    assign rd_valid_o   = rd_valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_ddr_burst_seq.sv
// Bench for ddr_burst_seq: directed vector table, two hand-written corner
// sequences, and random traffic against a timeline reference model.
module tb_ddr_burst_seq;

    localparam int TRCD = 2, CL = 2, BL = 4, TWR = 2, TRP = 2, TRFC = 8;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101,
                           C_WR = 3'b100, C_PRE = 3'b010, C_REF = 3'b001;
    localparam int NRAND = 2000;
    localparam int BIG   = 1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, rnw = 1'b0, ref_req = 1'b0;
    logic [1:0]  bank = 2'b00, be = 2'b11;
    logic [12:0] row = 13'h0;
    logic [9:0]  col = 10'h0;
    logic        ack, busy, wr_next, rd_valid, ref_ack, dqs_oe;
    logic [2:0]  cmd;
    logic [1:0]  ba, dm, dqs;
    logic [12:0] a;

    int total = 0;
    int bad = 0;

    ddr_burst_seq #(.ROW_BITS(13), .COL_BITS(10), .BANK_BITS(2), .TRCD(TRCD), .CL(CL),
                    .BL(BL), .TWR(TWR), .TRP(TRP), .TRFC(TRFC)) dut (
        .clock_i(clk), .reset_ni(rst_n), .req_i(req), .rnw_i(rnw), .bank_i(bank),
        .row_i(row), .col_i(col), .be_i(be), .ack_o(ack), .busy_o(busy),
        .wr_next_o(wr_next), .rd_valid_o(rd_valid), .ref_req_i(ref_req),
        .ref_ack_o(ref_ack), .ddr_cmd_o(cmd), .ddr_ba_o(ba), .ddr_a_o(a),
        .ctl_dm_o(dm), .ctl_dqs_o(dqs), .ctl_dqs_oe_o(dqs_oe));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [26:0] mk(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                                       input logic [1:0] m, input logic [1:0] q, input logic oe,
                                       input logic ak, input logic rak, input logic wn,
                                       input logic rv, input logic bz);
        return {c, b, ad, m, q, oe, ak, rak, wn, rv, bz};
    endfunction

    function automatic logic [26:0] dut_outs(input logic chk_ba, input logic chk_a);
        return mk(cmd, chk_ba ? ba : 2'b00, chk_a ? a : 13'h0, dm, dqs, dqs_oe,
                  ack, ref_ack, wr_next, rd_valid, busy);
    endfunction

    // Reset held two clocks; inputs idle. Returns right after release.
    task automatic do_reset();
        req = 1'b0; ref_req = 1'b0; be = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit is_ref; bit is_req; bit rnw;
        logic [1:0] bank; logic [12:0] row; logic [9:0] col;
        logic [1:0] be0; logic [1:0] be1;
        int e_refack; int e_act; int e_rw; int e_ack; int e_pre; int e_idle;
        logic [2:0] e_rwcmd; logic [1:0] e_dm0; logic [1:0] e_dm1;
    } vec_t;

    typedef struct {
        logic [2:0] cmd; logic [1:0] ba; logic [12:0] a; logic chk_ba; logic chk_a;
        logic [1:0] dm; logic [1:0] dqs; logic oe; logic ack; logic rack;
        logic wn; logic rv; logic busy;
    } exp_t;

    vec_t vecs[6];
    exp_t expv[0:NRAND+63];
    logic [1:0] be_arr[0:NRAND+63];

    initial begin
        // Directed table: expected event cycles counted from the request cycle 0.
        vecs[0] = '{0,1,0, 2'd1, 13'h1ABC, 10'h155, 2'b11, 2'b11, -1, 1, 3, 5, 9, 12, C_WR, 2'b00, 2'b00};
        vecs[1] = '{0,1,1, 2'd2, 13'h0123, 10'h3FF, 2'b11, 2'b11, -1, 1, 3, 6, 7, 10, C_RD, 2'b11, 2'b11};
        vecs[2] = '{0,1,0, 2'd3, 13'h0000, 10'h000, 2'b01, 2'b10, -1, 1, 3, 5, 9, 12, C_WR, 2'b10, 2'b01};
        vecs[3] = '{1,0,0, 2'd0, 13'h0000, 10'h000, 2'b11, 2'b11,  1, -1, -1, -1, -1, 10, C_NOP, 2'b11, 2'b11};
        vecs[4] = '{1,1,1, 2'd0, 13'h1FFF, 10'h001, 2'b11, 2'b11,  1, 11, 13, 16, 17, 20, C_RD, 2'b11, 2'b11};
        vecs[5] = '{1,1,0, 2'd1, 13'h0AAA, 10'h2AA, 2'b10, 2'b01,  1, 11, 13, 15, 19, 22, C_WR, 2'b01, 2'b10};

        for (int v = 0; v < 6; v++) begin
            int g_refack, g_act, g_rw, g_ack, g_pre, g_idle, n_wn;
            logic [2:0] g_rwcmd; logic [12:0] g_rwa, g_prea; logic [1:0] g_dm0, g_dm1;
            g_refack = -1; g_act = -1; g_rw = -1; g_ack = -1; g_pre = -1; g_idle = -1; n_wn = 0;
            g_rwcmd = C_NOP; g_rwa = 13'h0; g_prea = 13'h0; g_dm0 = 2'b11; g_dm1 = 2'b11;
            do_reset();
            req = vecs[v].is_req; ref_req = vecs[v].is_ref; rnw = vecs[v].rnw;
            bank = vecs[v].bank; row = vecs[v].row; col = vecs[v].col; be = vecs[v].be0;
            for (int c = 1; c < 30; c++) begin
                @(posedge clk); #1;
                if (ref_ack && g_refack < 0) g_refack = c;
                if (cmd == C_ACT && g_act < 0) g_act = c;
                if ((cmd == C_RD || cmd == C_WR) && g_rw < 0) begin g_rw = c; g_rwcmd = cmd; g_rwa = a; end
                if (ack && g_ack < 0) g_ack = c;
                if (cmd == C_PRE && g_pre < 0) begin g_pre = c; g_prea = a; end
                if (wr_next) begin
                    if (n_wn == 0) g_dm0 = dm; else g_dm1 = dm;
                    n_wn++;
                    be = vecs[v].be1;
                end
                if (!busy && g_idle < 0 && (g_pre >= 0 || (!vecs[v].is_req && g_refack >= 0))) g_idle = c;
                if (ack) req = 1'b0;
                if (ref_ack) ref_req = 1'b0;
            end
            check($sformatf("v%0d_refack", v), 64'(g_refack), 64'(vecs[v].e_refack));
            check($sformatf("v%0d_idle", v), 64'(g_idle), 64'(vecs[v].e_idle));
            if (vecs[v].is_req) begin
                check($sformatf("v%0d_act", v), 64'(g_act), 64'(vecs[v].e_act));
                check($sformatf("v%0d_rw", v), 64'(g_rw), 64'(vecs[v].e_rw));
                check($sformatf("v%0d_rwcmd", v), 64'(g_rwcmd), 64'(vecs[v].e_rwcmd));
                check($sformatf("v%0d_rw_addr", v), 64'(g_rwa), 64'({3'b000, vecs[v].col}));
                check($sformatf("v%0d_ack", v), 64'(g_ack), 64'(vecs[v].e_ack));
                check($sformatf("v%0d_pre", v), 64'(g_pre), 64'(vecs[v].e_pre));
                check($sformatf("v%0d_pre_a10", v), 64'(g_prea), 64'(13'h0400));
                check($sformatf("v%0d_dm0", v), 64'(g_dm0), 64'(vecs[v].e_dm0));
                check($sformatf("v%0d_dm1", v), 64'(g_dm1), 64'(vecs[v].e_dm1));
            end else begin
                check($sformatf("v%0d_no_act", v), 64'(g_act), 64'(-1));
            end
        end

        // Reset asserted in the middle of a write data phase.
        begin
            logic [26:0] rst_vec;
            rst_vec = mk(C_NOP, 2'b00, 13'h0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            do_reset();
            check("rst_initial", 64'(dut_outs(1'b1, 1'b1)), 64'(rst_vec));
            req = 1'b1; rnw = 1'b0; bank = 2'd2; row = 13'h0F0F; col = 10'h0AB; be = 2'b00;
            repeat (4) @(posedge clk);
            #1 check("rst_pre_wr_next", 64'(wr_next), 64'(1'b1));
            #2 rst_n = 1'b0; req = 1'b0;
            #1 check("rst_immediate", 64'(dut_outs(1'b1, 1'b1)), 64'(rst_vec));
            repeat (2) @(posedge clk);
            #1 check("rst_held", 64'(dut_outs(1'b1, 1'b1)), 64'(rst_vec));
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_release_idle", 64'(dut_outs(1'b1, 1'b1)), 64'(rst_vec));
            req = 1'b1; rnw = 1'b1;
            @(posedge clk); #1;
            check("rst_then_act", 64'({cmd, ba, a}), 64'({C_ACT, 2'd2, 13'h0F0F}));
            req = 1'b0;
        end

        // Refresh raised during the write data phase waits for the access to finish.
        begin
            int g_pre, g_ref, g_rack, g_ack;
            g_pre = -1; g_ref = -1; g_rack = -1; g_ack = -1;
            do_reset();
            req = 1'b1; rnw = 1'b0; bank = 2'd1; row = 13'h0011; col = 10'h022; be = 2'b11;
            for (int c = 1; c < 20; c++) begin
                @(posedge clk); #1;
                if (cmd == C_PRE && g_pre < 0) g_pre = c;
                if (cmd == C_REF && g_ref < 0) g_ref = c;
                if (ref_ack && g_rack < 0) g_rack = c;
                if (ack && g_ack < 0) g_ack = c;
                if (c == 4) ref_req = 1'b1;
                if (ack) req = 1'b0;
                if (ref_ack) ref_req = 1'b0;
            end
            check("refmid_ack", 64'(g_ack), 64'(5));
            check("refmid_pre", 64'(g_pre), 64'(9));
            check("refmid_ref", 64'(g_ref), 64'(13));
            check("refmid_refack", 64'(g_rack), 64'(13));
        end

        // Random traffic against the timeline model.
        begin
            int free_at, req_ack_c, ref_ack_c;
            bit req_pend, ref_pend, r_rnw;
            logic [1:0] r_bank; logic [12:0] r_row; logic [9:0] r_col;
            for (int i = 0; i < NRAND + 64; i++) begin
                expv[i] = '{C_NOP, 2'b00, 13'h0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                be_arr[i] = 2'($urandom_range(0, 3));
            end
            free_at = 0; req_pend = 0; ref_pend = 0; req_ack_c = BIG; ref_ack_c = BIG;
            r_rnw = 0; r_bank = 2'b00; r_row = 13'h0; r_col = 10'h0;
            do_reset();
            for (int c = 0; c < NRAND; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                end
                check($sformatf("rand_c%0d", c), 64'(dut_outs(expv[c].chk_ba, expv[c].chk_a)),
                      64'(mk(expv[c].cmd, expv[c].chk_ba ? expv[c].ba : 2'b00,
                             expv[c].chk_a ? expv[c].a : 13'h0, expv[c].dm, expv[c].dqs,
                             expv[c].oe, expv[c].ack, expv[c].rack, expv[c].wn, expv[c].rv,
                             expv[c].busy)));
                if (req_pend && c > req_ack_c) req_pend = 0;
                if (ref_pend && c > ref_ack_c) ref_pend = 0;
                if (!req_pend && $urandom_range(0, 3) == 0 && c < NRAND - 40) begin
                    req_pend = 1; req_ack_c = BIG; r_rnw = 1'($urandom_range(0, 1));
                    r_bank = 2'($urandom_range(0, 3)); r_row = 13'($urandom);
                    r_col = 10'($urandom);
                end
                if (!ref_pend && $urandom_range(0, 15) == 0 && c < NRAND - 40) begin
                    ref_pend = 1; ref_ack_c = BIG;
                end
                req = req_pend; ref_req = ref_pend; rnw = r_rnw; bank = r_bank;
                row = r_row; col = r_col; be = be_arr[c];
                if (c >= free_at && ref_pend && ref_ack_c == BIG) begin
                    ref_ack_c = c + 1;
                    expv[c+1].cmd = C_REF; expv[c+1].rack = 1'b1;
                    free_at = c + 2 + TRFC;
                    for (int k = c + 1; k < free_at; k++) expv[k].busy = 1'b1;
                end else if (c >= free_at && req_pend && req_ack_c == BIG) begin
                    int w, last, pre;
                    w = c + 1 + TRCD;
                    expv[c+1].cmd = C_ACT; expv[c+1].ba = r_bank; expv[c+1].a = r_row;
                    expv[c+1].chk_ba = 1'b1; expv[c+1].chk_a = 1'b1;
                    expv[w].cmd = r_rnw ? C_RD : C_WR; expv[w].ba = r_bank;
                    expv[w].a = {3'b000, r_col}; expv[w].chk_ba = 1'b1; expv[w].chk_a = 1'b1;
                    if (!r_rnw) begin
                        expv[w].oe = 1'b1;
                        for (int d = w + 1; d <= w + BL / 2; d++) begin
                            expv[d].dqs = 2'b11; expv[d].oe = 1'b1; expv[d].wn = 1'b1;
                            expv[d].dm = ~be_arr[d-1];
                        end
                        last = w + BL / 2;
                        expv[last+1].oe = 1'b1;
                        pre = last + 2 + TWR;
                    end else begin
                        for (int d = w + CL; d < w + CL + BL / 2; d++) expv[d].rv = 1'b1;
                        last = w + CL + BL / 2 - 1;
                        pre = last + 1;
                    end
                    expv[last].ack = 1'b1; req_ack_c = last;
                    expv[pre].cmd = C_PRE; expv[pre].a = 13'h0400; expv[pre].chk_a = 1'b1;
                    free_at = pre + TRP + 1;
                    for (int k = c + 1; k < free_at; k++) expv[k].busy = 1'b1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_burst_seq.md
Name: ddr_burst_seq

Overview:
Single-port DDR SDRAM access sequencer that drives the iobs_flow IOB block and the DDR command pins.
- Accepts one read or write request at a time from the memory client (req/ack handshake).
- Closed-page policy: every access is ACTIVE -> READ/WRITE -> PRECHARGE-all.
- Sequences the DQS enable/preamble/postamble, DM masking and read-capture window with fixed cycle timing.
- Arbitrates auto-refresh against client requests.

Parameters:
ROW_BITS, 13, row address width, also the width of ddr_a_o; must be >= 11
COL_BITS, 10, column address width; must be <= 10
BANK_BITS, 2, bank address width
TRCD, 2, clocks from ACTIVE to READ/WRITE; must be >= 1
CL, 2, clocks from READ command to first rd_valid_o cycle; must be >= 1
BL, 4, burst length in DDR beats (2, 4 or 8); data phase lasts BL/2 clocks
TWR, 2, NOP clocks after write postamble before PRECHARGE
TRP, 2, NOP clocks after PRECHARGE
TRFC, 8, NOP clocks after REFRESH

Ports:
clock_i  in  1  system clock; all logic on the rising edge
reset_ni  in  1  asynchronous active-low reset
req_i  in  1  access request; held high until ack_o
rnw_i  in  1  1 = read, 0 = write; sampled on acceptance
bank_i  in  BANK_BITS  bank; sampled on acceptance
row_i  in  ROW_BITS  row; sampled on acceptance
col_i  in  COL_BITS  column; sampled on acceptance
be_i  in  2  write byte enables for the current data clock
ack_o  out  1  one-cycle pulse, request complete
busy_o  out  1  high whenever the sequencer is not in IDLE
wr_next_o  out  1  high during each write data clock; client advances its write data
rd_valid_o  out  1  high during each read capture clock
ref_req_i  in  1  refresh request; level, held until ref_ack_o
ref_ack_o  out  1  one-cycle pulse coincident with the REFRESH command
ddr_cmd_o  out  3  {ras_n, cas_n, we_n}
ddr_ba_o  out  BANK_BITS  bank address
ddr_a_o  out  ROW_BITS  address bus
ctl_dm_o  out  2  to iobs_flow ctl_dm_i
ctl_dqs_o  out  2  to iobs_flow ctl_dqs_i; DQS toggle enable
ctl_dqs_oe_o  out  1  DQS/DQ output enable (preamble + data + postamble)

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ddr_cmd_o=NOP (3'b111); ddr_ba_o=0; ddr_a_o=0; ctl_dm_o=2'b11; ctl_dqs_o=2'b00; ctl_dqs_oe_o=0; ack_o, ref_ack_o, wr_next_o, rd_valid_o, busy_o all 0.
- Reset asserted mid-operation aborts immediately to the reset values. No PRECHARGE is issued; the client re-initialises the device.
- Command encodings: NOP 111, ACT 011, READ 101, WRITE 100, PRE 010 (A10=1), REF 001.
- IDLE arbitration: if ref_req_i=1, the refresh is taken (refresh beats req_i when both are high). Otherwise, if req_i=1, the request is accepted and the address/rnw are captured.
- A refresh never interrupts an access in progress.
- Accept at clock n:
  - n+1: ACT, ddr_a_o=row, ddr_ba_o=bank.
  - n+1+TRCD: READ or WRITE. ddr_a_o = column zero-extended, with A10=0.
- Write path:
  - WRITE cycle: ctl_dqs_oe_o=1 (preamble).
  - Next BL/2 clocks: ctl_dqs_o=2'b11, ctl_dm_o=~be_i, wr_next_o=1.
  - ack_o pulses on the last data clock.
  - Then 1 postamble clock: ctl_dqs_oe_o=1, ctl_dqs_o=00.
  - Then TWR NOP clocks, then PRE.
- Read path:
  - rd_valid_o=1 for BL/2 clocks starting at READ+CL.
  - ack_o pulses on the last rd_valid_o clock.
  - PRE on the following clock.
- After PRE: TRP NOP clocks, then IDLE. A new request can be accepted on the first IDLE clock.
- Refresh path: REF is issued and ref_ack_o pulses on the clock after the refresh is taken. Then TRFC NOP clocks, then IDLE.
- ctl_dm_o=2'b11 on every clock outside write data clocks.
- A single down-counter, sized to the largest timing parameter, provides all waits.
- States: IDLE, ACT, TRCD_W, RW_CMD, WR_DATA, WR_POST, TWR_W, RD_WAIT, RD_DATA, PRE, TRP_W, REF, TRFC_W.
- req_i dropping before ack_o is a protocol violation. The sequencer completes the access regardless.

Decomposition:
- Package ddr_pkg: command encodings (CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF), the state enumeration, and the DM_MASKED=2'b11 constant.
- One natural sub-module: ddr_wait_ctr, a loadable down-counter with a done flag, shared by all timed states.

Test Plan (defaults):
- Reset held for 2 clocks mid-write -> all outputs at reset values within the same cycle as reset assertion; ctl_dm_o=11; state IDLE after release.
- Write accepted at clk 0, be_i=2'b11 -> ACT@1, WRITE@3 with oe=1, dqs=11/dm=00/wr_next@4-5, ack@5, postamble@6, PRE@9, busy_o low @12.
- Read accepted at clk 0 -> ACT@1, READ@3, rd_valid@5-6, ack@6, PRE@7, IDLE@10.
- ref_req_i and req_i high together in IDLE -> REF with ref_ack@1, NOP 2-9, then the request's ACT@11.
- ref_req_i raised during a write data phase -> burst and PRE complete unchanged; REF on the clock after the return to IDLE.
- Write with be_i=2'b01 on the first data clock and 2'b10 on the second -> ctl_dm_o=10 then 01; ddr_a_o=col with A10=0 at WRITE, A10=1 at PRE.
